// File: rtl/blk_pack.sv
// blk_pack: packs 32-bit host words into 128-bit blocks held in a two-slot FIFO.
// It also drives the start and continue inputs of the AES block-interface state machine.
// Optional feature macro: BLK_PACK_PAD_EN. When it is defined, a short final block is
// zero-padded. When it is undefined, a short final block is dropped and oErr is set.
module blk_pack (
  input  logic         iClk,
  input  logic         iRstN,
  input  logic [31:0]  iData,
  input  logic         iDataVal,
  input  logic         iDataLast,
  output logic         oDataRdy,
  input  logic         iClr,
  input  logic         iSmReady,
  input  logic         iSmStart,
  input  logic         iSmEnd,
  output logic         oStart,
  output logic         oCont,
  output logic [127:0] oBlk,
  output logic         oErr
);

  logic [127:0] slot_q [2];
  logic [127:0] slot_d [2];
  logic [1:0]   last_q, last_d;
  logic [1:0]   count_q, count_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic [1:0]   widx_q, widx_d;
  logic         cur_last_q, cur_last_d;
  logic         err_q, err_d;

  logic accept;
  logic pop;
  logic push;
  logic push_last;

  assign oDataRdy = (count_q != 2'd2) && !iClr;
  assign oStart   = iSmReady && (count_q != 2'd0);
  assign oCont    = (count_q != 2'd0) && !cur_last_q;
  assign oBlk     = slot_q[rptr_q];
  assign oErr     = err_q;

  assign accept = iDataVal && oDataRdy;
  assign pop    = iSmStart && (count_q != 2'd0);

  // Next-state: word packing, push/pop bookkeeping, message-last tracking and flush.
  always_comb begin
    slot_d     = slot_q;
    last_d     = last_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    widx_d     = widx_q;
    cur_last_d = cur_last_q;
    err_d      = err_q;
    push       = 1'b0;
    push_last  = 1'b0;

    if (iSmEnd) begin
      cur_last_d = 1'b0;
    end
    // A pop in the same cycle as an end marks the start of a new message, so it wins.
    if (pop) begin
      rptr_d     = ~rptr_q;
      cur_last_d = last_q[rptr_q];
    end

    if (accept) begin
      // The free slot at wptr is written in place. The first word goes to the top bits.
      for (int k = 0; k < 4; k++) begin
        if (int'(widx_q) == k) begin
          slot_d[wptr_q][127-32*k -: 32] = iData;
        end
      end
      if (widx_q == 2'd3) begin
        push      = 1'b1;
        push_last = iDataLast;
        widx_d    = 2'd0;
      end else if (iDataLast) begin
`ifdef BLK_PACK_PAD_EN
        for (int k = 1; k < 4; k++) begin
          if (k > int'(widx_q)) begin
            slot_d[wptr_q][127-32*k -: 32] = 32'h0;
          end
        end
        push      = 1'b1;
        push_last = 1'b1;
        widx_d    = 2'd0;
`else
        widx_d = 2'd0;
        err_d  = 1'b1;
`endif
      end else begin
        widx_d = widx_q + 2'd1;
      end
    end

    if (push) begin
      last_d[wptr_q] = push_last;
      wptr_d         = ~wptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // A flush forces curLast to 1 so that a block already in the engine ends its message.
    if (iClr) begin
      count_d    = 2'd0;
      widx_d     = 2'd0;
      wptr_d     = 1'b0;
      rptr_d     = 1'b0;
      err_d      = 1'b0;
      cur_last_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
      last_q     <= '0;
      count_q    <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      widx_q     <= '0;
      cur_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      slot_q[0]  <= slot_d[0];
      slot_q[1]  <= slot_d[1];
      last_q     <= last_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      widx_q     <= widx_d;
      cur_last_q <= cur_last_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_blk_pack.sv
// tb_blk_pack: directed and randomized checks of blk_pack against a queue-based message model.
// The model follows the pad or no-pad behaviour selected by BLK_PACK_PAD_EN.
module tb_blk_pack;

  logic         iClk;
  logic         iRstN;
  logic [31:0]  iData;
  logic         iDataVal;
  logic         iDataLast;
  logic         oDataRdy;
  logic         iClr;
  logic         iSmReady;
  logic         iSmStart;
  logic         iSmEnd;
  logic         oStart;
  logic         oCont;
  logic [127:0] oBlk;
  logic         oErr;

  blk_pack u_dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iData     (iData),
    .iDataVal  (iDataVal),
    .iDataLast (iDataLast),
    .oDataRdy  (oDataRdy),
    .iClr      (iClr),
    .iSmReady  (iSmReady),
    .iSmStart  (iSmStart),
    .iSmEnd    (iSmEnd),
    .oStart    (oStart),
    .oCont     (oCont),
    .oBlk      (oBlk),
    .oErr      (oErr)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model state: complete blocks waiting, the partial message words, and the flags.
  logic [127:0] m_blk  [$];
  logic         m_last [$];
  logic [31:0]  m_words[$];
  logic         m_cur_last;
  logic         m_err;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_blk.delete();
    m_last.delete();
    m_words.delete();
    m_cur_last = 1'b0;
    m_err      = 1'b0;
  endtask

  function automatic logic [127:0] words_to_blk();
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < m_words.size(); i++) b[127-32*i -: 32] = m_words[i];
    return b;
  endfunction

  task automatic model_step(input logic val, input logic [31:0] d, input logic last,
                            input logic clr, input logic st, input logic en);
    int  sz;
    logic acc;
    sz  = m_blk.size();
    acc = val && (sz < 2) && !clr;
    if (clr) begin
      m_blk.delete();
      m_last.delete();
      m_words.delete();
      m_cur_last = 1'b1;
      m_err      = 1'b0;
      return;
    end
    if (en) m_cur_last = 1'b0;
    if (st && sz != 0) begin
      m_cur_last = m_last[0];
      void'(m_blk.pop_front());
      void'(m_last.pop_front());
    end
    if (acc) begin
      m_words.push_back(d);
      if (m_words.size() == 4) begin
        m_blk.push_back(words_to_blk());
        m_last.push_back(last);
        m_words.delete();
      end else if (last) begin
`ifdef BLK_PACK_PAD_EN
        m_blk.push_back(words_to_blk());
        m_last.push_back(1'b1);
`else
        m_err = 1'b1;
`endif
        m_words.delete();
      end
    end
  endtask

  task automatic check_outputs(input logic clr, input logic rdy);
    int sz;
    sz = m_blk.size();
    check_eq("oDataRdy", {127'b0, oDataRdy}, {127'b0, (sz < 2) && !clr});
    check_eq("oStart", {127'b0, oStart}, {127'b0, rdy && (sz != 0)});
    check_eq("oCont", {127'b0, oCont}, {127'b0, (sz != 0) && !m_cur_last});
    check_eq("oErr", {127'b0, oErr}, {127'b0, m_err});
    if (sz != 0) check_eq("oBlk", oBlk, m_blk[0]);
  endtask

  // One clock: drive at the falling edge, check outputs, then advance the model at the rising edge.
  task automatic step(input logic val, input logic [31:0] d, input logic last, input logic clr,
                      input logic rdy, input logic st, input logic en);
    @(negedge iClk);
    iDataVal  = val;
    iData     = d;
    iDataLast = last;
    iClr      = clr;
    iSmReady  = rdy;
    iSmStart  = st;
    iSmEnd    = en;
    #1;
    check_outputs(clr, rdy);
    @(posedge iClk);
    model_step(val, d, last, clr, st, en);
  endtask

  task automatic idle(input logic rdy, input logic st, input logic en);
    step(1'b0, 32'h0, 1'b0, 1'b0, rdy, st, en);
  endtask

  initial begin
    logic [31:0] w [4];
    logic        val, last, clr, rdy, st, en;
    w[0] = 32'h00112233;
    w[1] = 32'h44556677;
    w[2] = 32'h8899aabb;
    w[3] = 32'hccddeeff;

    iRstN = 1'b0; iData = '0; iDataVal = 1'b0; iDataLast = 1'b0;
    iClr = 1'b0; iSmReady = 1'b1; iSmStart = 1'b0; iSmEnd = 1'b0;
    model_reset();
    #1;
    check_eq("rst_oBlk", oBlk, 128'h0);
    check_eq("rst_oStart", {127'b0, oStart}, 128'h0);
    check_eq("rst_oCont", {127'b0, oCont}, 128'h0);
    check_eq("rst_oErr", {127'b0, oErr}, 128'h0);
    check_eq("rst_oDataRdy", {127'b0, oDataRdy}, 128'h1);
    @(negedge iClk);
    iRstN = 1'b1;

    // Single block with the state machine idle.
    for (int i = 0; i < 4; i++) step(1'b1, w[i], i == 3, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    check_eq("single_blk", oBlk, 128'h00112233_44556677_8899aabb_ccddeeff);
    check_eq("single_start", {127'b0, oStart}, 128'h1);
    idle(1'b1, 1'b1, 1'b0);
    #2;
    check_eq("single_cont_after_pop", {127'b0, oCont}, 128'h0);
    idle(1'b0, 1'b0, 1'b1);

    // Short final block: last flag on the second word.
    step(1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBBBBBB, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
`ifdef BLK_PACK_PAD_EN
    check_eq("pad_blk", oBlk, {32'hAAAAAAAA, 32'hBBBBBBBB, 64'h0});
    check_eq("pad_start", {127'b0, oStart}, 128'h1);
    check_eq("pad_err", {127'b0, oErr}, 128'h0);
    idle(1'b1, 1'b1, 1'b0);
    #2;
    check_eq("pad_cont", {127'b0, oCont}, 128'h0);
    idle(1'b0, 1'b0, 1'b1);
`else
    check_eq("nopad_err", {127'b0, oErr}, 128'h1);
    check_eq("nopad_start", {127'b0, oStart}, 128'h0);
    // A clean block after the discard must start from word 0.
    for (int i = 0; i < 4; i++) step(1'b1, w[i], i == 3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("nopad_repack", oBlk, 128'h00112233_44556677_8899aabb_ccddeeff);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("clr_err", {127'b0, oErr}, 128'h0);
`endif

    // Asynchronous reset in the middle of a block.
    step(1'b1, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge iClk);
    iDataVal = 1'b0; iSmReady = 1'b1; iSmStart = 1'b0; iSmEnd = 1'b0; iClr = 1'b0;
    #2;
    iRstN = 1'b0;
    #1;
    check_eq("mid_rst_oBlk", oBlk, 128'h0);
    check_eq("mid_rst_oStart", {127'b0, oStart}, 128'h0);
    check_eq("mid_rst_oCont", {127'b0, oCont}, 128'h0);
    check_eq("mid_rst_oErr", {127'b0, oErr}, 128'h0);
    check_eq("mid_rst_oDataRdy", {127'b0, oDataRdy}, 128'h1);
    model_reset();
    #1;
    iRstN = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, w[3-i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_eq("post_rst_blk", oBlk, 128'hccddeeff_8899aabb_44556677_00112233);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      val  = ($urandom % 4) != 0;
      last = ($urandom % 6) == 0;
      clr  = ($urandom % 80) == 0;
      rdy  = $urandom % 2;
      st   = rdy && (m_blk.size() != 0) && ($urandom % 2);
      en   = ($urandom % 8) == 0;
      step(val, $urandom, last, clr, rdy, st, en);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
